// File: rtl/multicycle_ctrl.sv
// Sequencing controller for a multi-cycle MIPS datapath with shared instruction/data memory.
// Define JUMP_EN to compile the JUMP state and dispatch opcode 000010 to it.
//
// state  | meaning
// -------+-------------------------------------------------
// FETCH  | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE | branch target into ALUOut, dispatch on opcode
// MEMADR | effective address for lw/sw
// MEMRD  | data read, wait for mem_ready
// MEMWB  | MDR into rt
// MEMWR  | data write, wait for mem_ready
// EXEC   | R-type ALU operation
// RWB    | ALUOut into rd
// BRANCH | beq compare, conditional PC load from ALUOut
// JUMP   | PC <= jump target (JUMP_EN only)
// IEXEC  | addi ALU operation
// IWB    | ALUOut into rt
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             zf,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             illegal_op,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_RWB    = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
`ifdef JUMP_EN
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [5:0] OP_J     = 6'b000010;
`endif
   localparam logic [3:0] S_IEXEC  = 4'd10;
   localparam logic [3:0] S_IWB    = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   logic [3:0]       state_q;
   logic [3:0]       state_d;
   logic             is_store;
   logic             op_legal;
   logic [3:0]       dispatch;
   logic             retire;
   logic [CNT_W-1:0] retired_q;

   logic pc_write, pc_write_cond;
   logic mem_read_i, mem_write_i, ir_write_i, reg_write_i, illegal_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // opcode is only valid in DECODE, so MEMADR needs lw/sw remembered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_store <= 1'b0;
      end else if (state_q == S_DECODE) begin
         is_store <= (opcode == OP_SW);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
      end else if (retire) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      op_legal = 1'b1;
      dispatch = S_FETCH;
      case (opcode)
         OP_RTYPE:     dispatch = S_EXEC;
         OP_LW, OP_SW: dispatch = S_MEMADR;
         OP_BEQ:       dispatch = S_BRANCH;
         OP_ADDI:      dispatch = S_IEXEC;
`ifdef JUMP_EN
         OP_J:         dispatch = S_JUMP;
`endif
         default:      op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: state_d = dispatch;
         S_MEMADR: state_d = is_store ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_RWB;
         S_IEXEC:  state_d = S_IWB;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      retire = 1'b0;
      case (state_q)
         S_MEMWB, S_RWB, S_BRANCH, S_IWB: retire = 1'b1;
`ifdef JUMP_EN
         S_JUMP:                          retire = 1'b1;
`endif
         S_MEMWR:                         retire = mem_ready;
         default:                         retire = 1'b0;
      endcase
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read_i    = 1'b0;
      mem_write_i   = 1'b0;
      ir_write_i    = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write_i   = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_i     = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_i = 1'b1;
            alu_src_b  = 2'b01;
            ir_write_i = mem_ready;
            pc_write   = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            illegal_i = ~op_legal;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_read_i = 1'b1;
            i_or_d     = 1'b1;
         end
         S_MEMWB: begin
            reg_write_i = 1'b1;
            mem_to_reg  = 1'b1;
         end
         S_MEMWR: begin
            mem_write_i = 1'b1;
            i_or_d      = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_RWB: begin
            reg_write_i = 1'b1;
            reg_dst     = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
`ifdef JUMP_EN
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
`endif
         S_IEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_IWB: begin
            reg_write_i = 1'b1;
         end
         default: begin
            alu_src_b = 2'b00;
         end
      endcase
   end

   // state already sits in FETCH during reset; only the strobes need masking
   assign pc_en      = rst_n & (pc_write | (pc_write_cond & zf));
   assign mem_read   = rst_n & mem_read_i;
   assign mem_write  = rst_n & mem_write_i;
   assign ir_write   = rst_n & ir_write_i;
   assign reg_write  = rst_n & reg_write_i;
   assign illegal_op = rst_n & illegal_i;
   assign state      = state_q;
   assign retired    = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style sequencing controller that drives a multi-cycle MIPS datapath from a single shared instruction/data memory. Each instruction moves through fetch, decode, execute, memory and write-back states. The block emits the per-cycle mux selects and write strobes, and stalls on a memory ready handshake. It replaces the single-cycle opcode decoder when the datapath is rebuilt around shared IR/MDR/A/B/ALUOut registers.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], sampled only in DECODE
- zf  in  1  ALU zero flag, used only in BRANCH
- mem_ready  in  1  memory completes the access in the current cycle
- pc_en  out  1  PC load = pc_write | (pc_write_cond & zf)
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut
- mem_read, mem_write  out  1 each  memory strobes
- ir_write  out  1  IR load
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- reg_write  out  1  register-file write
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext, 11 = sign-ext<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state encoding (debug)
- retired  out  CNT_W  count of completed instructions

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - When mem_ready=1: ir_write=1, pc_write=1, then go to DECODE.
  - Otherwise hold FETCH. ir_write and pc_en stay 0.
- DECODE: alu_src_b=11, alu_op=00 (branch target into ALUOut). Dispatch on opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → IEXEC
  - 000010 → JUMP (only with JUMP_EN)
  - anything else: illegal_op=1 for that cycle, then FETCH. retired is not incremented.
- MEMADR: alu_src_a=1, alu_src_b=10. Go to MEMRD on lw, MEMWR on sw.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Then FETCH.
- JUMP: pc_write=1, pc_source=10. Then FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Then IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
- Every output not listed for a state is 0.
- retired increments by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready=1), RWB, BRANCH, JUMP or IWB. It wraps modulo 2^CNT_W.

## Timing
- State register and retired are updated on the rising clk edge. All control outputs are combinational from state, plus mem_ready and zf where stated above.
- Reset: the state register goes to FETCH asynchronously and retired goes to 0. While rst_n=0, every strobe (pc_en, ir_write, mem_read, mem_write, reg_write, illegal_op) is forced to 0. Selects take their FETCH values.
- Reset deasserted mid-instruction aborts the instruction. The first edge after release is in FETCH.
- Latency with mem_ready tied 1: R-type, addi and lw-without-load take 4 cycles; lw takes 5; sw takes 4; beq and j take 3.
- Each low cycle of mem_ready adds one cycle in FETCH, MEMRD or MEMWR. Strobes stay stable during a stall.
- mem_ready is ignored in all other states.

## Configuration
- JUMP_EN defined: opcode 000010 dispatches to JUMP.
- JUMP_EN undefined: the JUMP state is not compiled, and opcode 000010 is treated as illegal (illegal_op pulse, back to FETCH).
- Either way, the state encodings of the other states are unchanged.

## Test plan
- Reset then add with mem_ready=1: states 0→1→6→7→0, reg_write high only in state 7, retired=1 after 4 cycles.
- lw with mem_ready low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. mem_read and i_or_d stay 1 through the stall. Total 7 cycles.
- beq with zf=1 then zf=0: pc_en=1 in BRANCH for the first, 0 for the second. retired increments in both cases.
- Opcode 111111: illegal_op pulses for 1 cycle in DECODE, next state is 0, retired unchanged.
- j with JUMP_EN defined: 3 cycles, pc_source=10 and pc_en=1 in state 9. With JUMP_EN undefined, the same opcode raises illegal_op.
- rst_n dropped during MEMWR: strobes go to 0 immediately, state=0 and retired=0. After release, mem_read=1 in FETCH.
